// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC conversion scheduler: requests one conversion per channel,
// tags each result with its channel and writes it to the send FIFO.
module adc_scan_sequencer #(
  parameter int CH_W     = 3,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 16,
  parameter int CONV_GAP = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CH_W-1:0]         ch_count,
  output logic                    conv_req,
  output logic [CH_W-1:0]         conv_ch,
  input  logic                    conv_ack,
  input  logic                    conv_done,
  input  logic [DATA_W-1:0]       conv_data,
  output logic                    fifo_wr_en,
  output logic [TAG_W+DATA_W-1:0] fifo_din,
  input  logic                    fifo_prog_full,
  output logic                    busy,
  output logic                    stalled,
  output logic                    timeout_err,
  output logic [15:0]             scan_count
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(CONV_GAP + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CONV_GAP - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, GAP} state_t;

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] ch_last;
  logic [CH_W-1:0] ch_nxt;
  logic            wrap;
  logic [TO_W-1:0] tcnt;
  logic [GAP_W-1:0] gcnt;
  logic            gap_hold;

  function automatic logic [TAG_W+DATA_W-1:0] pack_word(input logic [CH_W-1:0] c,
                                                       input logic [DATA_W-1:0] d);
    pack_word = {TAG_W'(c), d};
  endfunction

  assign wrap   = (ch == ch_last);
  assign ch_nxt = wrap ? '0 : ch + 1'b1;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      ch_last     <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
      gap_hold    <= 1'b0;
      conv_req    <= 1'b0;
      conv_ch     <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= '0;
      stalled     <= 1'b0;
      timeout_err <= 1'b0;
      scan_count  <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          stalled <= start && fifo_prog_full;
          if (start && !fifo_prog_full) begin
            ch_last     <= ch_count;
            ch          <= '0;
            timeout_err <= 1'b0;
            conv_req    <= 1'b1;
            conv_ch     <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (conv_ack) begin
            conv_req <= 1'b0;
            // A result arriving together with the ack skips the wait entirely.
            if (conv_done) begin
              fifo_din   <= pack_word(ch, conv_data);
              fifo_wr_en <= 1'b1;
              state      <= WRITE;
            end else begin
              tcnt  <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (conv_done) begin
            fifo_din   <= pack_word(ch, conv_data);
            fifo_wr_en <= 1'b1;
            state      <= WRITE;
          end else if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            gcnt        <= '0;
            state       <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WRITE: begin
          gcnt  <= '0;
          state <= GAP;
        end
        GAP: begin
          if (gap_hold) begin
            // Channel already advanced; only waiting for FIFO room.
            if (!start) begin
              gap_hold <= 1'b0;
              stalled  <= 1'b0;
              state    <= IDLE;
            end else if (!fifo_prog_full) begin
              gap_hold <= 1'b0;
              stalled  <= 1'b0;
              conv_req <= 1'b1;
              conv_ch  <= ch;
              state    <= REQ;
            end
          end else if (gcnt == GAP_LAST) begin
            ch <= ch_nxt;
            if (wrap) begin
              ch_last    <= ch_count;
              scan_count <= scan_count + 16'd1;
            end
            if (!start) begin
              state <= IDLE;
            end else if (fifo_prog_full) begin
              gap_hold <= 1'b1;
              stalled  <= 1'b1;
            end else begin
              conv_req <= 1'b1;
              conv_ch  <= ch_nxt;
              state    <= REQ;
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: SPI-engine responder, FIFO scoreboard and
// directed scan scenarios.
module tb_adc_scan_sequencer;
  localparam int CH_W     = 3;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 16;
  localparam int CONV_GAP = 4;
  localparam int TIMEOUT  = 1024;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [CH_W-1:0]         ch_count = '0;
  logic                    conv_req;
  logic [CH_W-1:0]         conv_ch;
  logic                    conv_ack = 1'b0;
  logic                    conv_done = 1'b0;
  logic [DATA_W-1:0]       conv_data = '0;
  logic                    fifo_wr_en;
  logic [TAG_W+DATA_W-1:0] fifo_din;
  logic                    fifo_prog_full = 1'b0;
  logic                    busy;
  logic                    stalled;
  logic                    timeout_err;
  logic [15:0]             scan_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] sb[$];
  int exp_ch = 0, exp_last = 0, exp_scan = 0;
  int ack_dly = 1, done_dly = 20, no_done_ch = -1;
  int acked_cnt = 0, ch_acked = -1, ack_cyc = 0;
  int wr_cnt = 0, last_wr_ch = -1, last_wr_cyc = 0, wr_period = 0;

  adc_scan_sequencer #(
    .CH_W(CH_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .CONV_GAP(CONV_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_count(ch_count),
    .conv_req(conv_req), .conv_ch(conv_ch), .conv_ack(conv_ack),
    .conv_done(conv_done), .conv_data(conv_data),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_prog_full(fifo_prog_full), .busy(busy), .stalled(stalled),
    .timeout_err(timeout_err), .scan_count(scan_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI engine model; also tracks which channel the scan should be on.
  initial begin
    int ok;
    forever begin
      @(negedge clk);
      if (rst_n && conv_req) begin
        check("conv_ch", 64'(conv_ch), 64'(exp_ch));
        ok = 1;
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge clk);
          if (!rst_n) ok = 0;
        end
        if (ok == 1 && rst_n && conv_req) begin
          conv_ack = 1'b1;
          @(negedge clk);
          conv_ack = 1'b0;
          ch_acked = exp_ch;
          acked_cnt++;
          ack_cyc = cyc;
          if (exp_ch == exp_last) begin
            exp_ch   = 0;
            exp_last = int'(ch_count);
            exp_scan++;
          end else begin
            exp_ch++;
          end
          if (ch_acked != no_done_ch) begin
            for (int i = 1; i < done_dly; i++) @(negedge clk);
            conv_done = 1'b1;
            conv_data = 16'(32'h1000 + ch_acked);
            sb.push_back({16'(ch_acked), 16'(32'h1000 + ch_acked)});
            @(negedge clk);
            conv_done = 1'b0;
          end
        end
      end
    end
  end

  // FIFO-side monitor.
  initial begin
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && fifo_wr_en) begin
        check("wr_single_cycle", 64'(prev_wr), 64'd0);
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check("fifo_din", 64'(fifo_din), 64'(sb.pop_front()));
        wr_cnt++;
        last_wr_ch  = int'(fifo_din[TAG_W+DATA_W-1:DATA_W]);
        wr_period   = cyc - last_wr_cyc;
        last_wr_cyc = cyc;
      end
      prev_wr = fifo_wr_en;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic go(input int cc);
    ch_count = CH_W'(cc);
    exp_ch   = 0;
    exp_last = cc;
    start    = 1'b1;
  endtask

  task automatic wait_wr(input int n, input string tag);
    int k = 0;
    while (wr_cnt < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(wr_cnt >= n), 64'd1);
  endtask

  task automatic stop_scan(input string tag);
    int k = 0;
    start = 1'b0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_scan_count"}, 64'(scan_count), 64'(exp_scan & 32'hFFFF));
  endtask

  initial begin
    int base, reqs, k;

    repeat (3) @(negedge clk);
    check("rst_conv_req", 64'(conv_req), 64'd0);
    check("rst_conv_ch", 64'(conv_ch), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_din", 64'(fifo_din), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stalled", 64'(stalled), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_scan", 64'(scan_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray done while idle must not produce a write.
    conv_done = 1'b1;
    conv_data = 16'hBEEF;
    @(negedge clk);
    conv_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_ignored", 64'(wr_cnt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Basic scan over channels 0..3.
    go(3);
    wait_wr(4, "t1_four_writes");
    check("t1_last_ch", 64'(last_wr_ch), 64'd3);
    repeat (CONV_GAP + 1) @(negedge clk);
    check("t1_scan_one", 64'(scan_count), 64'd1);
    wait_wr(5, "t1_fifth_write");
    check("t1_wrap_ch", 64'(last_wr_ch), 64'd0);
    stop_scan("t1");

    // Single channel with immediate responder: period 3+CONV_GAP.
    ack_dly  = 0;
    done_dly = 1;
    base = wr_cnt;
    go(0);
    wait_wr(base + 4, "t2_writes");
    check("t2_period", 64'(wr_period), 64'(3 + CONV_GAP));
    check("t2_ch", 64'(last_wr_ch), 64'd0);
    stop_scan("t2");

    // FIFO back-pressure: at start and during channel 2's gap.
    ack_dly  = 1;
    done_dly = 20;
    fifo_prog_full = 1'b1;
    go(3);
    repeat (5) @(negedge clk);
    check("t3_idle_stalled", 64'(stalled), 64'd1);
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_idle_no_req", 64'(conv_req), 64'd0);
    fifo_prog_full = 1'b0;
    base = wr_cnt;
    wait_wr(base + 3, "t3_three_writes");
    check("t3_ch2_written", 64'(last_wr_ch), 64'd2);
    fifo_prog_full = 1'b1;
    reqs = 0;
    repeat (50) begin
      @(negedge clk);
      if (conv_req) reqs++;
    end
    check("t3_hold_no_req", 64'(reqs), 64'd0);
    check("t3_hold_stalled", 64'(stalled), 64'd1);
    check("t3_hold_busy", 64'(busy), 64'd1);
    fifo_prog_full = 1'b0;
    @(negedge clk);
    check("t3_release_req", 64'(conv_req), 64'd1);
    check("t3_release_ch", 64'(conv_ch), 64'd3);
    check("t3_release_stalled", 64'(stalled), 64'd0);
    wait_wr(base + 5, "t3_after_release");
    check("t3_wrap_ch", 64'(last_wr_ch), 64'd0);
    stop_scan("t3");

    // Channel 1 never completes.
    no_done_ch = 1;
    go(3);
    k = 0;
    while (!timeout_err && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("t4_timeout_set", 64'(timeout_err), 64'd1);
    check("t4_timeout_cycles", 64'(cyc - ack_cyc), 64'(TIMEOUT));
    no_done_ch = -1;
    base = wr_cnt;
    wait_wr(base + 2, "t4_after_timeout");
    check("t4_next_ch", 64'(last_wr_ch), 64'd3);
    stop_scan("t4");
    check("t4_sticky", 64'(timeout_err), 64'd1);
    go(3);
    repeat (3) @(negedge clk);
    check("t4_cleared", 64'(timeout_err), 64'd0);
    stop_scan("t4b");

    // Drop start while waiting on channel 5.
    base = acked_cnt + 6;
    go(7);
    k = 0;
    while (acked_cnt < base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("t5_in_wait_ch5", 64'(ch_acked), 64'd5);
    stop_scan("t5");
    check("t5_ch5_written", 64'(last_wr_ch), 64'd5);
    reqs = 0;
    repeat (30) begin
      @(negedge clk);
      if (conv_req) reqs++;
    end
    check("t5_no_more_req", 64'(reqs), 64'd0);

    // ch_count change mid-scan takes effect only after the wrap.
    base = wr_cnt;
    go(7);
    wait_wr(base + 4, "t6_first_half");
    ch_count = 3'd2;
    wait_wr(base + 12, "t6_after_wrap");
    check("t6_wrap_to_0", 64'(last_wr_ch), 64'd0);
    stop_scan("t6");

    // Asynchronous reset during a request.
    ack_dly = 10;
    go(3);
    k = 0;
    while (!conv_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t7_req_seen", 64'(conv_req), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t7_rst_req", 64'(conv_req), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_wr", 64'(fifo_wr_en), 64'd0);
    check("t7_rst_scan", 64'(scan_count), 64'd0);
    repeat (15) @(negedge clk);
    check("t7_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    exp_scan = 0;
    exp_ch   = 0;
    exp_last = 3;
    ack_dly  = 1;
    base = wr_cnt;
    rst_n = 1'b1;
    wait_wr(base + 2, "t7_restart");
    check("t7_restart_ch", 64'(last_wr_ch), 64'd1);
    stop_scan("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
